// File: rtl/param_datapath_pkg.sv
// Shared types and defaults for the parametrised register-file/ALU datapath.
package dp_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_NREGS = 8;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        EXEC  = 2'b10,
        WRITE = 2'b11
    } seq_state_e;

    typedef enum logic [1:0] {
        D_IDLE  = 2'b00,
        D_PRESS = 2'b01,
        D_HELD  = 2'b10,
        D_REL   = 2'b11
    } deb_state_e;

endpackage

// File: rtl/param_datapath_btn_debouncer.sv
// Push-button synchroniser and debounce FSM; emits one pulse per debounced
// press, and re-arms only after a debounced release.
module btn_debouncer
    import dp_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 25000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic       sync1_q;
    logic       sync2_q;
    deb_state_e state_q;
    deb_state_e state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic       pulse_q;
    logic       pulse_d;

    // Two-flop synchroniser for the asynchronous button level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // Debounce state, stability counter and pulse register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= D_IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    // Next-state: any level change while counting restarts the count
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            D_IDLE: begin
                if (sync2_q) begin
                    state_d = D_PRESS;
                    cnt_d   = '0;
                end else begin
                    state_d = D_IDLE;
                end
            end
            D_PRESS: begin
                if (!sync2_q) begin
                    state_d = D_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = D_HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            D_HELD: begin
                if (!sync2_q) begin
                    state_d = D_REL;
                    cnt_d   = '0;
                end else begin
                    state_d = D_HELD;
                end
            end
            D_REL: begin
                if (sync2_q) begin
                    state_d = D_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = D_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = D_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode: pulse on the D_PRESS to D_HELD transition only
    always_comb begin
        pulse_d = 1'b0;
        if (state_q == D_PRESS && sync2_q && cnt_q == CNT_LAST) begin
            pulse_d = 1'b1;
        end else begin
            pulse_d = 1'b0;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/param_datapath.sv
// Button-driven register-file/ALU datapath: read, execute, writeback per press.
// Optional SAT_ARITH_EN makes add/sub saturate instead of wrapping.
module param_datapath
    import dp_pkg::*;
#(
    parameter  int WIDTH           = DEF_WIDTH,
    parameter  int NREGS           = DEF_NREGS,
    parameter  int DEBOUNCE_CYCLES = 25000000,
    localparam int AW              = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ext_data,
    input  logic [AW-1:0]    addr_src1,
    input  logic [AW-1:0]    addr_src2,
    input  logic [AW-1:0]    addr_dest,
    input  logic             is_external,
    input  logic [1:0]       alu_sel,
    input  logic             push_button,
    output logic [WIDTH-1:0] rdd1,
    output logic [WIDTH-1:0] rdd2,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             busy,
    output logic             done
);

    logic             pulse_s;
    seq_state_e       state_q;
    seq_state_e       state_d;
    logic             cap_en_s;
    logic             rd_en_s;
    logic             ex_en_s;
    logic             wr_en_s;
    logic             busy_q;
    logic             busy_d;
    logic             done_q;
    logic             done_d;

    logic [AW-1:0]    src1_q;
    logic [AW-1:0]    src2_q;
    logic [AW-1:0]    dest_q;
    logic             ext_q;
    alu_op_e          op_q;
    logic [WIDTH-1:0] ext_data_q;

    logic [WIDTH-1:0] rf_q [NREGS];
    logic [WIDTH-1:0] rdd1_q;
    logic [WIDTH-1:0] rdd2_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             carry_q;

    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_carry_s;

    btn_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .clk    (clk),
        .rst_n  (reset),
        .btn_i  (push_button),
        .pulse_o(pulse_s)
    );

    // Sequencer state and handshake registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Sequencer next state; pulses seen outside IDLE are simply dropped
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pulse_s) begin
                    state_d = READ;
                end else begin
                    state_d = IDLE;
                end
            end
            READ:    state_d = EXEC;
            EXEC:    state_d = WRITE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sequencer output decode
    always_comb begin
        cap_en_s = (state_q == IDLE) && pulse_s;
        rd_en_s  = (state_q == READ);
        ex_en_s  = (state_q == EXEC);
        wr_en_s  = (state_q == WRITE);
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == WRITE);
    end

    // Command capture at acceptance so switches may change mid-command
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src1_q     <= '0;
            src2_q     <= '0;
            dest_q     <= '0;
            ext_q      <= 1'b0;
            op_q       <= ALU_ADD;
            ext_data_q <= '0;
        end else if (cap_en_s) begin
            src1_q     <= addr_src1;
            src2_q     <= addr_src2;
            dest_q     <= addr_dest;
            ext_q      <= is_external;
            op_q       <= alu_op_e'(alu_sel);
            ext_data_q <= ext_data;
        end
    end

    // ALU with one extra bit so the MSB carries the carry/borrow
    always_comb begin
        sum_s       = '0;
        alu_res_s   = '0;
        alu_carry_s = 1'b0;
        case (op_q)
            ALU_ADD: begin
                sum_s       = {1'b0, rdd1_q} + {1'b0, rdd2_q};
                alu_res_s   = sum_s[WIDTH-1:0];
                alu_carry_s = sum_s[WIDTH];
            end
            ALU_SUB: begin
                sum_s       = {1'b0, rdd1_q} - {1'b0, rdd2_q};
                alu_res_s   = sum_s[WIDTH-1:0];
                alu_carry_s = sum_s[WIDTH];
            end
            ALU_AND: alu_res_s = rdd1_q & rdd2_q;
            ALU_OR:  alu_res_s = rdd1_q | rdd2_q;
            default: alu_res_s = '0;
        endcase
`ifdef SAT_ARITH_EN
        if (alu_carry_s && op_q == ALU_ADD) begin
            alu_res_s = '1;
        end else if (alu_carry_s && op_q == ALU_SUB) begin
            alu_res_s = '0;
        end else begin
            alu_res_s = alu_res_s;
        end
`endif
    end

    // Operand read, ALU status capture and register-file writeback
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
            rdd1_q   <= '0;
            rdd2_q   <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            if (rd_en_s) begin
                rdd1_q <= rf_q[src1_q];
                rdd2_q <= rf_q[src2_q];
            end
            if (ex_en_s) begin
                result_q <= alu_res_s;
                zero_q   <= (alu_res_s == '0);
                carry_q  <= alu_carry_s;
            end
            if (wr_en_s) begin
                rf_q[dest_q] <= ext_q ? ext_data_q : result_q;
            end
        end
    end

    assign rdd1   = rdd1_q;
    assign rdd2   = rdd2_q;
    assign result = result_q;
    assign zero   = zero_q;
    assign carry  = carry_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
